// File: rtl/demux4w_sched.sv
// One-word holding register that routes each accepted word to one of four channels, picked round-robin among the enabled channels.
// Optional per-channel delivery counters (cnt0..cnt3) are enabled by defining DEMUX4W_SCHED_CNT_EN.
module demux4w_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       chan_en,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       sel,
  output logic             busy
`ifdef DEMUX4W_SCHED_CNT_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1,
  output logic [15:0]      cnt2,
  output logic [15:0]      cnt3
`endif
);

  // Handshake: a word moves on any cycle where valid and ready are both high;
  // valid never waits on ready, and a raised valid holds its data until taken.
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       rr_ptr;
  logic [WIDTH-1:0] data_q;

  logic             any_en;
  logic             deliver;
  logic             accept;
  logic [1:0]       base;
  logic [1:0]       target;
  logic [1:0]       idx;

  assign any_en  = (chan_en != 4'b0000);
  assign deliver = (state == HOLD) && out_ready[sel];

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (state == EMPTY) in_ready = any_en;
      else                in_ready = out_ready[sel] && any_en;
    end
  end

  assign accept = in_valid && in_ready;

  // A word accepted in the same cycle as a delivery searches from the
  // post-delivery pointer, so back-to-back words keep rotating.
  always_comb begin
    base   = deliver ? (sel + 2'd1) : rr_ptr;
    target = base;
    idx    = base;
    for (int i = 3; i >= 0; i--) begin
      idx = base + i[1:0];
      if (chan_en[idx]) target = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      rr_ptr <= 2'd0;
      sel    <= 2'd0;
      data_q <= '0;
    end else begin
      if (deliver) rr_ptr <= sel + 2'd1;
      if (accept) begin
        state  <= HOLD;
        sel    <= target;
        data_q <= in_data;
      end else if (deliver) begin
        state <= EMPTY;
      end
    end
  end

  always_comb begin
    out_valid = 4'b0000;
    if (state == HOLD) out_valid[sel] = 1'b1;
  end

  assign out_data = data_q;
  assign busy     = (state == HOLD);

`ifdef DEMUX4W_SCHED_CNT_EN
  logic [15:0] cnt_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= 16'd0;
    end else if (deliver && (cnt_q[sel] != 16'hFFFF)) begin
      cnt_q[sel] <= cnt_q[sel] + 16'd1;
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux4w_sched.sv
// Randomized and directed bench for demux4w_sched; a transaction-level model predicts routing,
// and a negedge monitor checks each delivered word against the expected queue.
module tb_demux4w_sched;

  localparam int WIDTH = 8;
  localparam int W     = WIDTH + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [3:0]       chan_en = 4'b0000;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = 4'b0000;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       sel;
  logic             busy;
`ifdef DEMUX4W_SCHED_CNT_EN
  logic [15:0]      cnt0, cnt1, cnt2, cnt3;
`endif

  demux4w_sched #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .chan_en   (chan_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy)
`ifdef DEMUX4W_SCHED_CNT_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  // transaction-level reference: is a word held, for which channel, what data, where the search starts
  bit              m_hold = 1'b0;
  int              m_ch   = 0;
  logic [WIDTH-1:0] m_data = '0;
  int              m_ptr  = 0;
  bit              m_after_rst = 1'b0;
  int              m_cnt [4] = '{0, 0, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // one clock of stimulus; inputs change 1ns after the edge, checks 1ns later
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic [3:0] en,
                      input logic [3:0] ordy, input logic r);
    logic       exp_rdy;
    logic [3:0] exp_ov;
    int         tgt;
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_data = d; chan_en = en; out_ready = ordy;
    #1;
    if (r)           exp_rdy = 1'b0;
    else if (!m_hold) exp_rdy = (en != 4'b0000);
    else             exp_rdy = ordy[m_ch] && (en != 4'b0000);
    exp_ov = 4'b0000;
    if (m_hold) exp_ov[m_ch] = 1'b1;
    check("in_ready", in_ready, exp_rdy);
    check("busy", busy, m_hold);
    check("out_valid", out_valid, exp_ov);
    if (m_hold) begin
      check("out_data_held", out_data, m_data);
      check("sel_held", sel, m_ch);
    end
    if (m_after_rst) begin
      check("out_data_after_rst", out_data, 0);
      check("sel_after_rst", sel, 0);
    end
`ifdef DEMUX4W_SCHED_CNT_EN
    check("cnt0", cnt0, m_cnt[0]);
    check("cnt1", cnt1, m_cnt[1]);
    check("cnt2", cnt2, m_cnt[2]);
    check("cnt3", cnt3, m_cnt[3]);
`endif
    m_after_rst = 1'b0;
    if (r) begin
      m_hold = 1'b0;
      m_ptr  = 0;
      m_data = '0;
      m_cnt  = '{0, 0, 0, 0};
      m_after_rst = 1'b1;
      exp_q.delete();
    end else begin
      if (m_hold && ordy[m_ch]) begin
        m_ptr  = (m_ch + 1) % 4;
        m_hold = 1'b0;
        if (m_cnt[m_ch] < 65535) m_cnt[m_ch]++;
      end
      if (v && exp_rdy) begin
        tgt = -1;
        for (int k = 0; k < 4; k++)
          if (tgt < 0 && en[(m_ptr + k) % 4]) tgt = (m_ptr + k) % 4;
        m_hold = 1'b1;
        m_ch   = tgt;
        m_data = d;
        exp_q.push_back({tgt[1:0], d});
      end
    end
  endtask

  // monitor: a delivery is out_valid[k] & out_ready[k] seen at the negedge
  always @(negedge clk) begin
    if (!rst && ((out_valid & out_ready) != 4'b0000)) begin
      logic [W-1:0] e;
      int ch;
      ch = 0;
      for (int k = 0; k < 4; k++) if (out_valid[k]) ch = k;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL deliver_unexpected: got ch %0d data %0h expected no delivery at %0t",
                 ch, out_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("deliver_ch", ch, e[W-1:WIDTH]);
        check("deliver_data", out_data, e[WIDTH-1:0]);
      end
    end
  end

  initial begin
    step(0, 0, 4'hF, 4'hF, 1);
    step(0, 0, 4'hF, 4'hF, 1);
    step(0, 0, 4'hF, 4'hF, 0);

    // round-robin over all four channels
    for (int i = 0; i < 8; i++) step(1, 8'h10 + i[7:0], 4'b1111, 4'b1111, 0);
    step(0, 0, 4'b1111, 4'b1111, 0);

    // skip disabled channels 0 and 2
    for (int i = 0; i < 8; i++) step(1, 8'h20 + i[7:0], 4'b1010, 4'b1111, 0);
    step(0, 0, 4'b1010, 4'b1111, 0);

    // stall with nothing enabled and nothing held
    for (int i = 0; i < 3; i++) step(1, 8'h99, 4'b0000, 4'b1111, 0);

    // backpressure on channel 2; other channels' ready must be ignored
    step(0, 0, 4'hF, 4'hF, 1);
    step(1, 8'hA5, 4'b0100, 4'b0000, 0);
    for (int i = 0; i < 5; i++) step(1, 8'h5A, 4'b1111, 4'b1011, 0);
    step(1, 8'h5A, 4'b1111, 4'b1111, 0);
    step(0, 0, 4'b1111, 4'b1111, 0);

    // channel 1 disabled while its word is held
    step(0, 0, 4'hF, 4'hF, 1);
    step(1, 8'h3C, 4'b0010, 4'b0000, 0);
    step(0, 0, 4'b1101, 4'b0000, 0);
    step(1, 8'h44, 4'b1101, 4'b0010, 0);
    step(0, 0, 4'b1101, 4'b1111, 0);

    // reset while holding, then the next word must go to channel 0
    step(1, 8'h11, 4'b1111, 4'b1111, 0);
    step(1, 8'h22, 4'b1111, 4'b0000, 0);
    step(0, 0, 4'b1111, 4'b0000, 1);
    step(1, 8'h33, 4'b1111, 4'b1111, 0);
    step(0, 0, 4'b1111, 4'b1111, 0);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      logic [3:0] en;
      en = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), en,
           4'($urandom_range(0, 15)), ($urandom_range(0, 59) == 0));
    end

    // drain
    for (int i = 0; i < 4; i++) step(0, 0, 4'b1111, 4'b1111, 0);
    check("queue_drained", exp_q.size(), 0);

`ifdef DEMUX4W_SCHED_CNT_EN
    step(0, 0, 4'hF, 4'hF, 1);
    for (int i = 0; i < 70000; i++) step(1, 8'($urandom), 4'b0001, 4'b0001, 0);
    step(0, 0, 4'b0001, 4'b0001, 0);
    step(0, 0, 4'b0001, 4'b0001, 0);
    check("cnt0_saturated", cnt0, 16'hFFFF);
    check("queue_drained_cnt", exp_q.size(), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
